// File: rtl/multicycle_ctrl_if.sv
// Data-memory handshake between multicycle_ctrl (master) and datamem (slave).
// Handshake: mem_req is a level; MemRead/MemWrite stay stable while it is high, and the access ends on the one-cycle mem_ack pulse.
interface multicycle_ctrl_if;
  logic mem_req;
  logic MemRead;
  logic MemWrite;
  logic mem_ack;

  modport master (output mem_req, output MemRead, output MemWrite, input mem_ack);
  modport slave  (input mem_req, input MemRead, input MemWrite, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: FETCH->DECODE->EXEC->[MEM]->[WB], flag register, branch resolve.
// Optional MC_PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_ctrl #(
  parameter int OPW     = 11,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  multicycle_ctrl_if.master mem,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             Reg2Loc,
  output logic             ALUsrc,
  output logic [2:0]       ALUOp,
  output logic             ShiftDir,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             trap,
  output logic [2:0]       state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]      cyc_cnt,
  output logic [31:0]      ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_ADDI, C_ADDS, C_SUBS, C_LSL, C_LSR,
    C_LDUR, C_STUR, C_CBZ, C_BLT, C_B
  } cls_t;

  function automatic cls_t decode(input logic [OPW-1:0] op);
    casez (op)
      11'b1001000100?: decode = C_ADDI;
      11'b10101011000: decode = C_ADDS;
      11'b11101011000: decode = C_SUBS;
      11'b11010011011: decode = C_LSL;
      11'b11010011010: decode = C_LSR;
      11'b11111000010: decode = C_LDUR;
      11'b11111000000: decode = C_STUR;
      11'b10110100???: decode = C_CBZ;
      11'b01010100???: decode = C_BLT;
      11'b000101?????: decode = C_B;
      default:         decode = C_ILL;
    endcase
  endfunction

  state_t     state_q, state_nx;
  cls_t       cls_q, cls_in;
  logic       n_q, v_q;
  logic [3:0] wait_cnt, wait_nx;
  logic       trap_q, set_trap;
  logic       mem_req_c, mem_rd_c, mem_wr_c;

  assign cls_in = decode(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      cls_q    <= C_ILL;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      wait_cnt <= 4'd0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      wait_cnt <= wait_nx;
      if (state_q == S_DECODE) cls_q <= cls_in;
      if (state_q == S_EXEC && (cls_q == C_ADDS || cls_q == C_SUBS)) begin
        n_q <= alu_neg;
        v_q <= alu_ovf;
      end
      if (set_trap) trap_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state_q;
    wait_nx   = wait_cnt;
    set_trap  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    Reg2Loc   = 1'b0;
    ALUsrc    = 1'b0;
    ALUOp     = 3'b000;
    ShiftDir  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    mem_req_c = 1'b0;
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we    = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        // Register read ports are addressed while the opcode is still only on the IR
        Reg2Loc = (cls_in == C_STUR) || (cls_in == C_CBZ);
        if (cls_in == C_ILL) begin
          set_trap = 1'b1;
          state_nx = S_HALT;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        Reg2Loc  = (cls_q == C_STUR) || (cls_q == C_CBZ);
        state_nx = S_WB;
        case (cls_q)
          C_ADDI:         begin ALUOp = 3'b010; ALUsrc = 1'b1; end
          C_ADDS:         ALUOp = 3'b010;
          C_SUBS:         ALUOp = 3'b011;
          C_LSL:          begin ALUOp = 3'b111; ALUsrc = 1'b1; end
          C_LSR:          begin ALUOp = 3'b111; ALUsrc = 1'b1; ShiftDir = 1'b1; end
          C_LDUR, C_STUR: begin ALUOp = 3'b010; ALUsrc = 1'b1; state_nx = S_MEM; end
          C_CBZ:          begin pc_we = 1'b1; pc_sel = alu_zero;  state_nx = S_FETCH; end
          C_BLT:          begin pc_we = 1'b1; pc_sel = n_q ^ v_q; state_nx = S_FETCH; end
          C_B:            begin pc_we = 1'b1; pc_sel = 1'b1;      state_nx = S_FETCH; end
          default:        begin set_trap = 1'b1; state_nx = S_HALT; end
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_rd_c  = (cls_q == C_LDUR);
        mem_wr_c  = (cls_q == C_STUR);
        Reg2Loc   = (cls_q == C_STUR);
        if (mem.mem_ack) begin
          wait_nx = 4'd0;
          if (cls_q == C_LDUR) begin
            state_nx = S_WB;
          end else begin
            pc_we    = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (wait_cnt == 4'(TIMEOUT - 1)) begin
          wait_nx  = 4'd0;
          set_trap = 1'b1;
          state_nx = S_HALT;
        end else begin
          wait_nx = wait_cnt + 4'd1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (cls_q == C_LDUR);
        pc_we    = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = state_q;
    endcase
    // Nothing is strobed while reset is held, whatever state it interrupted
    if (rst) begin
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      Reg2Loc   = 1'b0;
      ALUsrc    = 1'b0;
      ALUOp     = 3'b000;
      ShiftDir  = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      mem_req_c = 1'b0;
      mem_rd_c  = 1'b0;
      mem_wr_c  = 1'b0;
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.MemRead  = mem_rd_c;
  assign mem.MemWrite = mem_wr_c;
  assign trap         = trap_q;
  assign state        = state_q;

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= 32'd0;
      ret_cnt <= 32'd0;
    end else begin
      if (state_q != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      if (pc_we)             ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule
